// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the write-back data cache.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    REFILL     = 2'd2
  } cache_state_t;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2i(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int calc_num_sets(input int cache_size, input int words_per_line, input int assoc);
    return cache_size / (4 * words_per_line * assoc);
  endfunction

  function automatic int calc_off(input int words_per_line);
    return clog2i(words_per_line);
  endfunction

  function automatic int calc_idx(input int cache_size, input int words_per_line, input int assoc);
    return clog2i(calc_num_sets(cache_size, words_per_line, assoc));
  endfunction

  function automatic int calc_tag(input int cache_size, input int words_per_line, input int assoc);
    return 30 - calc_idx(cache_size, words_per_line, assoc) - calc_off(words_per_line);
  endfunction

endpackage

// File: rtl/dcache_way_select.sv
// Per-set tag compare and replacement victim choice.
// Latency: combinational.
// Backpressure: none; pure function of the set state and request tag.
module dcache_way_select #(
  parameter int WAYS  = 2,
  parameter int TAG_W = 21,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0]             valid,
  input  logic [WAYS-1:0][TAG_W-1:0]  tags,
  input  logic [TAG_W-1:0]            req_tag,
  input  logic [WAY_W-1:0]            ptr,
  output logic                        hit,
  output logic [WAYS-1:0]             hit_way,
  output logic [WAY_W-1:0]            victim
);

  // Match every way; victim is the lowest invalid way, else the round-robin pointer.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = ptr;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w] && (tags[w] == req_tag)) begin
        hit_way[w] = 1'b1;
        hit        = 1'b1;
      end
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// Write-back, write-allocate set-associative data cache for the MEM stage.
// Latency: hits are zero-wait; misses stall 1+W cycles clean, 1+2W dirty, plus one per low mem_ready.
// Backpressure: stall is combinational to the pipeline; memory beats advance only on mem_ready.
module dcache_wb import dcache_pkg::*; #(
  parameter int CACHE_SIZE     = 4096,
  parameter int WORDS_PER_LINE = 4,
  parameter int ASSOCIATIVITY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_en,
  input  logic        read,
  input  logic        write,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready
);

  localparam int NUM_SETS  = calc_num_sets(CACHE_SIZE, WORDS_PER_LINE, ASSOCIATIVITY);
  localparam int OFF       = calc_off(WORDS_PER_LINE);
  localparam int IDX       = calc_idx(CACHE_SIZE, WORDS_PER_LINE, ASSOCIATIVITY);
  localparam int TAG_W     = calc_tag(CACHE_SIZE, WORDS_PER_LINE, ASSOCIATIVITY);
  // Field widths are kept at least 1 bit so degenerate geometries still elaborate.
  localparam int IDX_W     = (IDX > 0) ? IDX : 1;
  localparam int BEAT_W    = (OFF > 0) ? OFF : 1;
  localparam int WAY_W     = (ASSOCIATIVITY > 1) ? clog2i(ASSOCIATIVITY) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(ASSOCIATIVITY - 1);

  cache_state_t state;
  logic [BEAT_W-1:0] beat;
  logic [WAY_W-1:0]  victim_q;

  logic [NUM_SETS-1:0][ASSOCIATIVITY-1:0] valid_q;
  logic [NUM_SETS-1:0][ASSOCIATIVITY-1:0] dirty_q;
  logic [NUM_SETS-1:0][WAY_W-1:0]         ptr_q;
  logic [ASSOCIATIVITY-1:0][TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [31:0]                            data_q [NUM_SETS][ASSOCIATIVITY][WORDS_PER_LINE];

  logic [TAG_W-1:0]         req_tag;
  logic [IDX_W-1:0]         set_idx;
  logic [BEAT_W-1:0]        word_sel;
  logic                     tag_match;
  logic [ASSOCIATIVITY-1:0] hit_way;
  logic [WAY_W-1:0]         hit_idx;
  logic [WAY_W-1:0]         victim;
  logic [31:0]              merged;
  logic                     req;

  assign req      = read | write;
  assign req_tag  = TAG_W'(addr >> (IDX + OFF + 2));
  assign set_idx  = IDX_W'((addr >> (OFF + 2)) & (NUM_SETS - 1));
  assign word_sel = BEAT_W'((addr >> 2) & (WORDS_PER_LINE - 1));

  dcache_way_select #(
    .WAYS  (ASSOCIATIVITY),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_way_select (
    .valid   (valid_q[set_idx]),
    .tags    (tag_q[set_idx]),
    .req_tag (req_tag),
    .ptr     (ptr_q[set_idx]),
    .hit     (tag_match),
    .hit_way (hit_way),
    .victim  (victim)
  );

  // Encode the one-hot hit vector into a way number.
  always_comb begin
    hit_idx = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++)
      if (hit_way[w]) hit_idx = WAY_W'(w);
  end

  assign hit       = (state == IDLE) & tag_match;
  assign stall     = req & ((state != IDLE) | ~tag_match);
  // A store wins over a simultaneous load, so the load returns nothing.
  assign read_data = (read & ~write & hit) ? data_q[set_idx][hit_idx][word_sel] : 32'h0;
  assign mem_read  = (state == REFILL);
  assign mem_write = (state == WRITE_BACK);

  // Byte-lane merge of the store data into the currently addressed word.
  always_comb begin
    merged = data_q[set_idx][hit_idx][word_sel];
    for (int b = 0; b < 4; b++)
      if (byte_en[b]) merged[8*b +: 8] = write_data[8*b +: 8];
  end

  // Beat address/data toward memory; quiet while idle.
  always_comb begin
    mem_addr       = 32'h0;
    mem_write_data = 32'h0;
    case (state)
      WRITE_BACK: begin
        mem_addr       = (32'(tag_q[set_idx][victim_q]) << (IDX + OFF + 2)) |
                         (32'(set_idx) << (OFF + 2)) | (32'(beat) << 2);
        mem_write_data = data_q[set_idx][victim_q][beat];
      end
      REFILL: begin
        mem_addr = (32'(req_tag) << (IDX + OFF + 2)) |
                   (32'(set_idx) << (OFF + 2)) | (32'(beat) << 2);
      end
      default: ;
    endcase
  end

  // Miss-handling FSM plus the resettable line status bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat     <= '0;
      victim_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      ptr_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (tag_match) begin
              if (write) dirty_q[set_idx][hit_idx] <= 1'b1;
            end else begin
              victim_q <= victim;
              beat     <= '0;
              state    <= (valid_q[set_idx][victim] && dirty_q[set_idx][victim]) ? WRITE_BACK : REFILL;
            end
          end
        end
        WRITE_BACK: begin
          if (mem_ready) begin
            if (beat == LAST_BEAT) begin
              beat                       <= '0;
              dirty_q[set_idx][victim_q] <= 1'b0;
              state                      <= REFILL;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        REFILL: begin
          if (mem_ready) begin
            if (beat == LAST_BEAT) begin
              beat                       <= '0;
              valid_q[set_idx][victim_q] <= 1'b1;
              dirty_q[set_idx][victim_q] <= 1'b0;
              ptr_q[set_idx]             <= (victim_q == LAST_WAY) ? '0 : victim_q + 1'b1;
              state                      <= IDLE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage: store hits merge bytes, refill beats fill the victim line.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && write && tag_match)
      data_q[set_idx][hit_idx][word_sel] <= merged;
    if ((state == REFILL) && mem_ready) begin
      data_q[set_idx][victim_q][beat] <= mem_read_data;
      if (beat == LAST_BEAT) tag_q[set_idx][victim_q] <= req_tag;
    end
  end

endmodule
